// File: rtl/cache_fill_pkg.sv
// Purpose: shared types and constants for the data-cache miss/fill state machine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_fill_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;  // byte offset within a 16-byte block
  localparam int WORD_IDX_BITS     = 3;  // word index within a block

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    META = 2'd2
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Purpose: small wrapping word counter with synchronous clear, enable and terminal-count flag.
// Latency: count updates on the clock edge after clr/en; tc is combinational from the count.
// Backpressure: none; counts only when en is high.
//
// Ports: clk, rst_n (async active-low), clr (clear to 0, wins over en), en (increment),
//        cnt (current count), tc (count is all ones, i.e. next increment wraps).
module fill_word_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = &cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Purpose: miss handler for the 2-way data cache; fetches a 16-byte block as 8 words, writes them, then updates metadata.
// Latency: requests in the 8 cycles after the miss; tag write one cycle after the 8th returned word; idle the cycle after.
// Backpressure: fsm_busy stalls the pipeline for the whole fill; returns are counted, so memory may insert any gaps.
//
// Ports: clk, rst_n (async active-low); miss_detected/miss_address from the cache;
//        mem_en/mem_addr requests and memory_data_valid/memory_data returns to/from memory;
//        write_data_array/write_tag_array/cache_addr/cache_data to the cache arrays; fsm_busy stall.
// Optional: define CACHE_FILL_STATS_EN to add miss_count (saturating count of accepted misses).
module cache_fill_fsm
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = WORDS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [15:0]       miss_count
`endif
);

  localparam int IDX_BITS = $clog2(WORDS);
  localparam int OFF_BITS = IDX_BITS + 1;  // 16-bit words: word index sits above byte bit 0

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              req_done_q, req_done_d;

  logic                cnt_clr;
  logic                req_en;
  logic                ret_en;
  logic [IDX_BITS-1:0] req_cnt;
  logic [IDX_BITS-1:0] ret_cnt;
  logic                req_tc;
  logic                ret_tc;

  // Byte offset of the missing access is irrelevant: the whole block is fetched.
  logic unused_offset;
  assign unused_offset = ^miss_address[OFF_BITS-1:0];

  fill_word_counter #(.W(IDX_BITS)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (req_en),
    .cnt   (req_cnt),
    .tc    (req_tc)
  );

  fill_word_counter #(.W(IDX_BITS)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (ret_en),
    .cnt   (ret_cnt),
    .tc    (ret_tc)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    req_done_d       = req_done_q;
    cnt_clr          = 1'b0;
    req_en           = 1'b0;
    ret_en           = 1'b0;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_addr       = '0;

    case (state_q)
      IDLE: begin
        // Stall must begin in the miss cycle itself, before the state register moves.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          base_d     = {miss_address[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
          cnt_clr    = 1'b1;
          req_done_d = 1'b0;
          state_d    = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // Requests stop after eight; the done flag keeps the wrapped counter parked at 0.
        if (!req_done_q) begin
          mem_en   = 1'b1;
          mem_addr = base_q | {{(ADDR_W-OFF_BITS){1'b0}}, req_cnt, 1'b0};
          req_en   = 1'b1;
          if (req_tc) begin
            req_done_d = 1'b1;
          end
        end
        // Returns arrive in request order, so the return count is the word index.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          cache_addr       = base_q | {{(ADDR_W-OFF_BITS){1'b0}}, ret_cnt, 1'b0};
          ret_en           = 1'b1;
          if (ret_tc) begin
            state_d = META;
          end
        end
      end

      META: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        cache_addr      = base_q;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cache_data = memory_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      req_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      req_done_q <= req_done_d;
    end
  end

`ifdef CACHE_FILL_STATS_EN
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && miss_detected && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count_q <= '0;
    end else begin
      miss_count_q <= miss_count_d;
    end
  end

  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Purpose: directed self-checking bench for cache_fill_fsm with a 4-cycle memory model.
// Latency: checks every output cycle-by-cycle against hand-derived timing.
// Backpressure: also drives gapped returns directly to exercise valid counting.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_addr;
  logic [15:0] cache_data;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0] miss_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Memory model controls
  logic        use_model;
  logic        dir_vld;
  logic [15:0] dir_dat;
  logic [3:0]  pv;
  logic [15:0] pa0, pa1, pa2, pa3;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .mem_addr          (mem_addr),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_addr        (cache_addr),
    .cache_data        (cache_data)
`ifdef CACHE_FILL_STATS_EN
    ,
    .miss_count        (miss_count)
`endif
  );

  // 4-cycle memory: request seen in cycle N returns in cycle N+4; data = addr ^ 16'h5A5A.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv  <= '0;
      pa0 <= '0;
      pa1 <= '0;
      pa2 <= '0;
      pa3 <= '0;
    end else begin
      pv  <= {pv[2:0], mem_en};
      pa0 <= mem_addr;
      pa1 <= pa0;
      pa2 <= pa1;
      pa3 <= pa2;
    end
  end

  assign memory_data_valid = use_model ? pv[3] : dir_vld;
  assign memory_data       = use_model ? (pv[3] ? (pa3 ^ 16'h5A5A) : 16'h0000) : dir_dat;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one fill with the memory model. Cycle 0 (miss asserted) is the current cycle.
  // noise: hold a different miss during cycles 3..5; chain: assert next miss in cycle 14.
  task automatic run_fill(input string tag, input logic [15:0] addr, input bit skip_c0,
                          input bit noise, input bit chain, input logic [15:0] next_addr);
    logic [15:0] base;
    logic [15:0] exp_ma, exp_ca;
    bit          exp_men, exp_wda;
    int          n_req, n_wr;
    base  = {addr[15:4], 4'h0};
    n_req = 0;
    n_wr  = 0;
    if (!skip_c0) begin
      @(negedge clk);
      check_val($sformatf("%s c0 busy", tag), 32'(fsm_busy), 32'd1);
      check_val($sformatf("%s c0 mem_en", tag), 32'(mem_en), 32'd0);
    end
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      miss_detected = noise && (c >= 3) && (c <= 5);
      miss_address  = miss_detected ? 16'h5550 : addr;
      if (chain && c == 14) begin
        miss_detected = 1'b1;
        miss_address  = next_addr;
      end
      @(negedge clk);
      exp_men = (c >= 1) && (c <= 8);
      exp_ma  = exp_men ? base + 16'(2 * (c - 1)) : 16'h0000;
      exp_wda = (c >= 5) && (c <= 12);
      exp_ca  = exp_wda ? base + 16'(2 * (c - 5)) : ((c == 13) ? base : 16'h0000);
      if (mem_en) n_req++;
      if (write_data_array) n_wr++;
      check_val($sformatf("%s c%0d mem_en", tag, c), 32'(mem_en), 32'(exp_men));
      check_val($sformatf("%s c%0d mem_addr", tag, c), 32'(mem_addr), 32'(exp_ma));
      check_val($sformatf("%s c%0d wr_data", tag, c), 32'(write_data_array), 32'(exp_wda));
      check_val($sformatf("%s c%0d cache_addr", tag, c), 32'(cache_addr), 32'(exp_ca));
      check_val($sformatf("%s c%0d wr_tag", tag, c), 32'(write_tag_array), 32'(c == 13));
      check_val($sformatf("%s c%0d busy", tag, c), 32'(fsm_busy), 32'((c != 14) || chain));
      if (exp_wda)
        check_val($sformatf("%s c%0d cache_data", tag, c), 32'(cache_data), 32'(exp_ca ^ 16'h5A5A));
    end
    check_val($sformatf("%s req count", tag), 32'(n_req), 32'd8);
    check_val($sformatf("%s write count", tag), 32'(n_wr), 32'd8);
  endtask

  task automatic check_all_zero(input string tag);
    check_val($sformatf("%s busy", tag), 32'(fsm_busy), 32'd0);
    check_val($sformatf("%s mem_en", tag), 32'(mem_en), 32'd0);
    check_val($sformatf("%s mem_addr", tag), 32'(mem_addr), 32'd0);
    check_val($sformatf("%s wr_data", tag), 32'(write_data_array), 32'd0);
    check_val($sformatf("%s wr_tag", tag), 32'(write_tag_array), 32'd0);
    check_val($sformatf("%s cache_addr", tag), 32'(cache_addr), 32'd0);
    check_val($sformatf("%s cache_data", tag), 32'(cache_data), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    use_model     = 1'b1;
    dir_vld       = 1'b0;
    dir_dat       = 16'h0000;
    #2;
    check_all_zero("reset");
    #21;
    rst_n = 1'b1;

    // Partial fill interrupted by reset after three returns.
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h7774;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      miss_detected = 1'b0;
    end
    // Now in cycle 8: returns seen in cycles 5,6,7.
    rst_n = 1'b0;
    #1;
    check_all_zero("midfill rst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    run_fill("after_rst", 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Single miss with ignored miss during fill, then back-to-back miss.
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'hABCD;
    run_fill("single", 16'hABCD, 1'b0, 1'b1, 1'b1, 16'h2000);
    run_fill("b2b", 16'h2000, 1'b1, 1'b0, 1'b0, 16'h0000);

`ifdef CACHE_FILL_STATS_EN
    check_val("miss_count", 32'(miss_count), 32'd3);
`endif

    // Gapped returns: word k valid in cycle 3+3k, driven directly.
    use_model = 1'b0;
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h4446;
    begin
      int n_wr;
      int k;
      n_wr = 0;
      for (int c = 1; c <= 26; c++) begin
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        dir_vld = (c >= 3) && (c <= 24) && (((c - 3) % 3) == 0);
        k       = (c - 3) / 3;
        dir_dat = dir_vld ? 16'hC000 + 16'(k) : 16'h0000;
        @(negedge clk);
        if (write_data_array) n_wr++;
        check_val($sformatf("stall c%0d wr_data", c), 32'(write_data_array), 32'(dir_vld));
        if (dir_vld) begin
          check_val($sformatf("stall c%0d cache_addr", c), 32'(cache_addr), 32'(16'h4440 + 16'(2 * k)));
          check_val($sformatf("stall c%0d cache_data", c), 32'(cache_data), 32'(16'hC000 + 16'(k)));
        end
        check_val($sformatf("stall c%0d wr_tag", c), 32'(write_tag_array), 32'(c == 25));
        if (c == 25)
          check_val("stall meta addr", 32'(cache_addr), 32'h4440);
        check_val($sformatf("stall c%0d busy", c), 32'(fsm_busy), 32'(c != 26));
      end
      check_val("stall write count", 32'(n_wr), 32'd8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling state machine for the 2-way data cache: on a cache miss it reads the missing 16-byte block from main memory as eight 16-bit words. It writes each returned word into the cache data array, then issues one metadata (tag/valid/LRU) update. Sits between the data cache and the 4-cycle-latency unified memory, and stalls the pipeline for the whole fill.

## Interface
Parameters:
- ADDR_W, 16, address width (byte address).
- DATA_W, 16, word width.
- WORDS, 8, words per block (power of two; offset bits = log2(WORDS)+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- miss_detected  in  1  cache Miss.
- miss_address  in  16  CPU address of the missing access.
- fsm_busy  out  1  stall to pipeline; reset 0.
- mem_en  out  1  memory read request, one word per cycle; reset 0.
- mem_addr  out  16  request address; reset 0.
- memory_data_valid  in  1  returned word valid.
- memory_data  in  16  returned word.
- write_data_array  out  1  to cache Data_WE; reset 0.
- write_tag_array  out  1  to cache MetaData_WE; reset 0.
- cache_addr  out  16  to cache Addr_FSM; reset 0.
- cache_data  out  16  to cache DataIn_FSM; pass-through of memory_data.

## Operation
- States: IDLE, FILL, META.
- IDLE:
  - When miss_detected=1, latch base = {miss_address[15:4],4'b0}; next state FILL.
  - fsm_busy = miss_detected (combinational), so the stall starts in the miss cycle.
  - memory_data_valid is ignored.
- FILL:
  - Issue counter req_cnt (3-bit) 0..7: mem_en=1, mem_addr = base | {req_cnt,1'b0}; req_cnt increments each cycle.
  - After 8 requests, mem_en=0 and req_cnt holds at 0 (saturation flag set).
  - Return counter ret_cnt (3-bit) increments on each memory_data_valid.
  - While memory_data_valid=1: write_data_array=1, cache_addr = base | {ret_cnt,1'b0}, cache_data = memory_data.
  - When memory_data_valid=1 and ret_cnt=7: next state META.
- META, one cycle:
  - write_tag_array=1, cache_addr=base, write_data_array=0; next state IDLE.
- fsm_busy=1 in FILL and META.
- miss_detected during FILL/META is ignored, and base is not relatched.
- Memory returns words in request order; out-of-order return is not supported.
- Counters wrap 7→0 and are cleared on entry to FILL.
- Reset mid-fill: state returns to IDLE, counters cleared, all outputs 0 immediately (asynchronous). Memory shares rst_n, so no stale returns arrive after reset.

## Timing
- Miss seen in cycle 0 → mem_en in cycles 1..8.
- With 4-cycle memory latency, data valid in cycles 5..12 and write_data_array in cycles 5..12.
- write_tag_array in cycle 13; fsm_busy falls in cycle 14 (IDLE).
- The cache re-evaluates hit in cycle 14.
- Back-to-back misses: a new miss is accepted in the first IDLE cycle.
- Total fill overhead is latency-independent in logic: the FSM counts valids, not cycles.

## Configuration
- CACHE_FILL_STATS_EN: when defined, adds output miss_count (16-bit).
  - Increments on each IDLE→FILL transition and saturates at 0xFFFF; reset 0.
- When undefined, the port and its counter are absent; behaviour is otherwise identical.

## Structure
- Package cache_fill_pkg: state enum (IDLE, FILL, META), constants WORDS_PER_BLOCK=8, BLOCK_OFFSET_BITS=4, WORD_IDX_BITS=3.
- Sub-module fill_word_counter (3-bit, clear/enable, terminal-count flag), instantiated twice for req_cnt and ret_cnt.
- Target size: ~150-250 lines total.

## Test plan
- Reset: rst_n=0 mid-FILL (after 3 returns) → all outputs 0 immediately. A new miss at 0x1234 then fetches 0x1230..0x123E from word 0.
- Single miss: miss_address=0xABCD with 4-cycle memory → mem_addr 0xABC0,0xABC2,…,0xABCE in cycles 1..8.
  - write_data_array cycles 5..12, with cache_addr matching each returned word.
  - write_tag_array cycle 13 with cache_addr=0xABC0; fsm_busy 0 in cycle 14.
- Stalled memory: memory_data_valid gaps of 2 cycles between words → exactly 8 data writes in order, META only after the 8th.
- Ignore during busy: miss_address changes to 0x5550 with miss_detected=1 during FILL → base stays 0xABC0, no extra requests.
- Back-to-back: second miss 0x2000 asserted in the cycle fsm_busy falls → new fill starts next cycle with mem_addr 0x2000.
- Stats (CACHE_FILL_STATS_EN): three misses → miss_count=3. Preload 0xFFFF and miss → stays 0xFFFF.
